// File: rtl/user_ram_arbiter.sv
// Round-robin arbiter sharing the user table SRAM between the lobby (r0) and in-car (r1) keypad FSMs.
// Optional macro USER_RAM_LOCK_GUARD_EN: writes first pre-read the lock bit and are refused on a locked user.
module user_ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int PASS_W   = 16,
  parameter int CNT_W    = 4,
  parameter int USER_MAX = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [3:0]        r0_we,
  input  logic [3:0]        r1_we,
  input  logic [PASS_W-1:0] r0_pass_in,
  input  logic [PASS_W-1:0] r1_pass_in,
  input  logic [CNT_W-1:0]  r0_count_in,
  input  logic [CNT_W-1:0]  r1_count_in,
  input  logic              r0_admin_in,
  input  logic              r1_admin_in,
  input  logic              r0_lock_in,
  input  logic              r1_lock_in,
  output logic              r0_ack,
  output logic              r1_ack,
  output logic              r0_err,
  output logic              r1_err,
  output logic [PASS_W-1:0] rd_pass,
  output logic [CNT_W-1:0]  rd_count,
  output logic              rd_admin,
  output logic              rd_lock,
  output logic              ram_cs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_pass_rw,
  output logic              ram_count_rw,
  output logic              ram_admin_rw,
  output logic              ram_lock_rw,
  output logic [PASS_W-1:0] ram_pass_in,
  output logic [CNT_W-1:0]  ram_count_in,
  output logic              ram_admin_in,
  output logic              ram_lock_in,
  input  logic [PASS_W-1:0] ram_pass_out,
  input  logic [CNT_W-1:0]  ram_count_out,
  input  logic              ram_admin_out,
  input  logic              ram_lock_out
);

  // state     | meaning
  // IDLE      | arbitrate pending requests, latch the winner
  // ACCESS    | RAM strobes active for the latched access
  // CAPTURE   | RAM read data valid; load rd_*, pulse ack next cycle
  // ACCESS_RD | (guard) read-only pre-access of a write
  // CHECK     | (guard) inspect lock bit, issue or refuse the write
  typedef enum logic [2:0] {
    IDLE = 3'd0, ACCESS = 3'd1, CAPTURE = 3'd2
`ifdef USER_RAM_LOCK_GUARD_EN
    , ACCESS_RD = 3'd3, CHECK = 3'd4
`endif
  } state_t;

  state_t state, state_nx;
  logic last_grant, last_grant_nx, sel_q, sel_nx, valid_q, valid_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx, ram_addr_nx;
  logic [3:0] we_q, we_nx, rw_nx;
  logic [PASS_W-1:0] pass_q, pass_nx, ram_pass_in_nx, rd_pass_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, ram_count_in_nx, rd_count_nx;
  logic admin_q, admin_nx, lock_q, lock_nx;
  logic cs_nx, ram_admin_in_nx, ram_lock_in_nx, rd_admin_nx, rd_lock_nx;
  logic ack0_nx, ack1_nx, err0_nx, err1_nx, ok;
  logic block_q, block_nx;

  logic pend0, pend1, pick1, m_valid, m_admin, m_lock;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0] m_we;
  logic [PASS_W-1:0] m_pass;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic addr_ok(input logic [11:0] a);
    logic [11:0] v;
    v = 12'(a[11:8]) * 12'd100 + 12'(a[7:4]) * 12'd10 + 12'(a[3:0]);
    return (a[11:8] <= 4'd9) && (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9) &&
           (v >= 12'd1) && (v <= 12'(USER_MAX));
  endfunction

  // A requester whose ack is high this cycle is already served; skip it.
  assign pend0   = r0_req & ~r0_ack;
  assign pend1   = r1_req & ~r1_ack;
  assign pick1   = pend1 & (~pend0 | ~last_grant);
  assign m_addr  = pick1 ? r1_addr     : r0_addr;
  assign m_we    = pick1 ? r1_we       : r0_we;
  assign m_pass  = pick1 ? r1_pass_in  : r0_pass_in;
  assign m_cnt   = pick1 ? r1_count_in : r0_count_in;
  assign m_admin = pick1 ? r1_admin_in : r0_admin_in;
  assign m_lock  = pick1 ? r1_lock_in  : r0_lock_in;
  assign m_valid = addr_ok(m_addr);

`ifdef USER_RAM_LOCK_GUARD_EN
  assign ok = valid_q & ~block_q;
`else
  assign ok = valid_q;
  assign block_q = 1'b0;
  assign block_nx = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    last_grant_nx = last_grant;
    sel_nx = sel_q; valid_nx = valid_q; addr_nx = addr_q; we_nx = we_q;
    pass_nx = pass_q; cnt_nx = cnt_q; admin_nx = admin_q; lock_nx = lock_q;
`ifdef USER_RAM_LOCK_GUARD_EN
    block_nx = block_q;
`endif
    cs_nx = 1'b0; ram_addr_nx = '0; rw_nx = 4'b0000;
    ram_pass_in_nx = '0; ram_count_in_nx = '0; ram_admin_in_nx = 1'b0; ram_lock_in_nx = 1'b0;
    ack0_nx = 1'b0; ack1_nx = 1'b0; err0_nx = 1'b0; err1_nx = 1'b0;
    rd_pass_nx = rd_pass; rd_count_nx = rd_count; rd_admin_nx = rd_admin; rd_lock_nx = rd_lock;
    case (state)
      IDLE: if (pend0 | pend1) begin
        sel_nx = pick1; last_grant_nx = pick1; valid_nx = m_valid; addr_nx = m_addr;
        we_nx = m_we; pass_nx = m_pass; cnt_nx = m_cnt; admin_nx = m_admin; lock_nx = m_lock;
        cs_nx = m_valid;
        ram_addr_nx = m_valid ? m_addr : '0;
`ifdef USER_RAM_LOCK_GUARD_EN
        block_nx = 1'b0;
        if (m_we != 4'b0000) state_nx = ACCESS_RD;
        else
`endif
        begin
          state_nx = ACCESS;
          if (m_valid) begin
            rw_nx = m_we; ram_pass_in_nx = m_pass; ram_count_in_nx = m_cnt;
            ram_admin_in_nx = m_admin; ram_lock_in_nx = m_lock;
          end
        end
      end
      ACCESS: state_nx = CAPTURE;
      CAPTURE: begin
        state_nx = IDLE;
        if (ok) begin
          rd_pass_nx = ram_pass_out; rd_count_nx = ram_count_out;
          rd_admin_nx = ram_admin_out; rd_lock_nx = ram_lock_out;
        end
        ack0_nx = ~sel_q; ack1_nx = sel_q;
        err0_nx = ~sel_q & ~ok; err1_nx = sel_q & ~ok;
      end
`ifdef USER_RAM_LOCK_GUARD_EN
      ACCESS_RD: state_nx = CHECK;
      CHECK: begin
        state_nx = ACCESS;
        // A write may only touch a locked user if it is the unlock itself.
        block_nx = valid_q & ram_lock_out & ~(we_q[3] & ~lock_q);
        if (block_nx) begin
          rd_pass_nx = ram_pass_out; rd_count_nx = ram_count_out;
          rd_admin_nx = ram_admin_out; rd_lock_nx = ram_lock_out;
        end else if (valid_q) begin
          cs_nx = 1'b1; ram_addr_nx = addr_q; rw_nx = we_q;
          ram_pass_in_nx = pass_q; ram_count_in_nx = cnt_q;
          ram_admin_in_nx = admin_q; ram_lock_in_nx = lock_q;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; last_grant <= 1'b1;
      sel_q <= 1'b0; valid_q <= 1'b0; addr_q <= '0; we_q <= '0;
      pass_q <= '0; cnt_q <= '0; admin_q <= 1'b0; lock_q <= 1'b0;
      ram_cs <= 1'b0; ram_addr <= '0;
      {ram_lock_rw, ram_admin_rw, ram_count_rw, ram_pass_rw} <= 4'b0000;
      ram_pass_in <= '0; ram_count_in <= '0; ram_admin_in <= 1'b0; ram_lock_in <= 1'b0;
      r0_ack <= 1'b0; r1_ack <= 1'b0; r0_err <= 1'b0; r1_err <= 1'b0;
      rd_pass <= '0; rd_count <= '0; rd_admin <= 1'b0; rd_lock <= 1'b0;
    end else begin
      state <= state_nx; last_grant <= last_grant_nx;
      sel_q <= sel_nx; valid_q <= valid_nx; addr_q <= addr_nx; we_q <= we_nx;
      pass_q <= pass_nx; cnt_q <= cnt_nx; admin_q <= admin_nx; lock_q <= lock_nx;
      ram_cs <= cs_nx; ram_addr <= ram_addr_nx;
      {ram_lock_rw, ram_admin_rw, ram_count_rw, ram_pass_rw} <= rw_nx;
      ram_pass_in <= ram_pass_in_nx; ram_count_in <= ram_count_in_nx;
      ram_admin_in <= ram_admin_in_nx; ram_lock_in <= ram_lock_in_nx;
      r0_ack <= ack0_nx; r1_ack <= ack1_nx; r0_err <= err0_nx; r1_err <= err1_nx;
      rd_pass <= rd_pass_nx; rd_count <= rd_count_nx; rd_admin <= rd_admin_nx; rd_lock <= rd_lock_nx;
    end
  end

`ifdef USER_RAM_LOCK_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) block_q <= 1'b0;
    else     block_q <= block_nx;
  end
`endif

endmodule

// File: tb/tb_user_ram_arbiter.sv
// Directed bench for user_ram_arbiter with a behavioural sync SRAM model.
// Build with USER_RAM_LOCK_GUARD_EN to also exercise the lock guard.
module tb_user_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic r0_req = 0, r1_req = 0;
  logic [11:0] r0_addr = '0, r1_addr = '0;
  logic [3:0] r0_we = '0, r1_we = '0;
  logic [15:0] r0_pass_in = '0, r1_pass_in = '0;
  logic [3:0] r0_count_in = '0, r1_count_in = '0;
  logic r0_admin_in = 0, r1_admin_in = 0, r0_lock_in = 0, r1_lock_in = 0;
  logic r0_ack, r1_ack, r0_err, r1_err;
  logic [15:0] rd_pass; logic [3:0] rd_count; logic rd_admin, rd_lock;
  logic ram_cs; logic [11:0] ram_addr;
  logic ram_pass_rw, ram_count_rw, ram_admin_rw, ram_lock_rw;
  logic [15:0] ram_pass_in; logic [3:0] ram_count_in; logic ram_admin_in, ram_lock_in;
  logic [15:0] ram_pass_out = '0; logic [3:0] ram_count_out = '0;
  logic ram_admin_out = 0, ram_lock_out = 0;

  logic [15:0] mem_pass [0:4095];
  logic [3:0]  mem_count [0:4095];
  logic        mem_admin [0:4095];
  logic        mem_lock [0:4095];

  int n_chk = 0, n_bad = 0;

`ifdef USER_RAM_LOCK_GUARD_EN
  localparam int WLAT = 4;
  localparam bit GUARD = 1'b1;
`else
  localparam int WLAT = 2;
  localparam bit GUARD = 1'b0;
`endif

  user_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_we(r0_we), .r1_we(r1_we), .r0_pass_in(r0_pass_in), .r1_pass_in(r1_pass_in),
    .r0_count_in(r0_count_in), .r1_count_in(r1_count_in),
    .r0_admin_in(r0_admin_in), .r1_admin_in(r1_admin_in),
    .r0_lock_in(r0_lock_in), .r1_lock_in(r1_lock_in),
    .r0_ack(r0_ack), .r1_ack(r1_ack), .r0_err(r0_err), .r1_err(r1_err),
    .rd_pass(rd_pass), .rd_count(rd_count), .rd_admin(rd_admin), .rd_lock(rd_lock),
    .ram_cs(ram_cs), .ram_addr(ram_addr),
    .ram_pass_rw(ram_pass_rw), .ram_count_rw(ram_count_rw),
    .ram_admin_rw(ram_admin_rw), .ram_lock_rw(ram_lock_rw),
    .ram_pass_in(ram_pass_in), .ram_count_in(ram_count_in),
    .ram_admin_in(ram_admin_in), .ram_lock_in(ram_lock_in),
    .ram_pass_out(ram_pass_out), .ram_count_out(ram_count_out),
    .ram_admin_out(ram_admin_out), .ram_lock_out(ram_lock_out)
  );

  always #5 clk = ~clk;

  // Sync SRAM: read returns the old contents, write lands on the same edge.
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_pass_out  <= mem_pass[ram_addr];
      ram_count_out <= mem_count[ram_addr];
      ram_admin_out <= mem_admin[ram_addr];
      ram_lock_out  <= mem_lock[ram_addr];
      if (ram_pass_rw)  mem_pass[ram_addr]  <= ram_pass_in;
      if (ram_count_rw) mem_count[ram_addr] <= ram_count_in;
      if (ram_admin_rw) mem_admin[ram_addr] <= ram_admin_in;
      if (ram_lock_rw)  mem_lock[ram_addr]  <= ram_lock_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one access and check cs/strobes on the grant edge and the ack timing.
  task automatic xfer(input bit who, input logic [11:0] a, input logic [3:0] we,
                      input logic [15:0] p, input logic [3:0] c, input logic lk,
                      input logic exp_cs, input logic [3:0] exp_rw,
                      input logic exp_err, input int lat);
    if (!who) begin
      r0_req = 1; r0_addr = a; r0_we = we; r0_pass_in = p; r0_count_in = c; r0_lock_in = lk;
    end else begin
      r1_req = 1; r1_addr = a; r1_we = we; r1_pass_in = p; r1_count_in = c; r1_lock_in = lk;
    end
    tick();
    chk("cs", ram_cs, exp_cs);
    chk("rw", {ram_lock_rw, ram_admin_rw, ram_count_rw, ram_pass_rw}, exp_rw);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("early_ack", who ? r1_ack : r0_ack, 0);
    end
    tick();
    chk("ack", who ? r1_ack : r0_ack, 1);
    chk("other_ack", who ? r0_ack : r1_ack, 0);
    chk("err", who ? r1_err : r0_err, exp_err);
    r0_req = 0; r1_req = 0;
  endtask

  task automatic idle1();
    tick();
    chk("ack_low", {r1_ack, r0_ack}, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_pass[i] = '0; mem_count[i] = '0; mem_admin[i] = 0; mem_lock[i] = 0;
    end
    mem_pass[12'h042] = 16'h1234; mem_count[12'h042] = 4'h3; mem_admin[12'h042] = 1;
    mem_pass[12'h007] = 16'h5555; mem_count[12'h007] = 4'h9;
    mem_pass[12'h010] = 16'h0A10;
    mem_pass[12'h128] = 16'h0128; mem_count[12'h128] = 4'h5;
    mem_pass[12'h005] = 16'h0555; mem_lock[12'h005] = 1;

    rst = 1; tick(); tick();
    chk("rst_cs", ram_cs, 0);
    chk("rst_ack", {r1_ack, r0_ack}, 0);
    chk("rst_err", {r1_err, r0_err}, 0);
    chk("rst_rd", {rd_pass, rd_count, rd_admin, rd_lock}, 0);
    rst = 0;

    // read user 42
    xfer(0, 12'h042, 4'b0000, 16'h0, 4'h0, 0, 1, 4'b0000, 0, 2);
    chk("t1_pass", rd_pass, 16'h1234);
    chk("t1_count", rd_count, 4'h3);
    chk("t1_admin", rd_admin, 1);
    idle1();

    // write pass/count of user 7, rd returns pre-write contents; then read back
    xfer(0, 12'h007, 4'b0011, 16'h9876, 4'h0, 0, 1, GUARD ? 4'b0000 : 4'b0011, 0, WLAT);
    chk("t4_old_pass", rd_pass, 16'h5555);
    chk("t4_old_count", rd_count, 4'h9);
    idle1();
    chk("t4_mem", mem_pass[12'h007], 16'h9876);
    xfer(0, 12'h007, 4'b0000, 16'h0, 4'h0, 0, 1, 4'b0000, 0, 2);
    chk("t4_pass", rd_pass, 16'h9876);
    chk("t4_count", rd_count, 4'h0);
    idle1();

    // range boundary: 128 valid, then invalid addresses leave rd_* alone
    xfer(1, 12'h128, 4'b0000, 16'h0, 4'h0, 0, 1, 4'b0000, 0, 2);
    chk("t3_128", rd_pass, 16'h0128);
    idle1();
    xfer(1, 12'h129, 4'b0000, 16'h0, 4'h0, 0, 0, 4'b0000, 1, 2);
    chk("t3_129_hold", rd_pass, 16'h0128);
    idle1();
    xfer(1, 12'h000, 4'b0001, 16'hFFFF, 4'h0, 0, 0, 4'b0000, 1, GUARD ? 4 : 2);
    chk("t3_000_hold", rd_pass, 16'h0128);
    idle1();
    xfer(1, 12'h0A5, 4'b0000, 16'h0, 4'h0, 0, 0, 4'b0000, 1, 2);
    chk("t3_0a5_hold", {rd_pass, rd_count}, {16'h0128, 4'h5});
    idle1();

    // ties right after reset: r0, r1, r0, r1 with both reqs held
    rst = 1; tick(); rst = 0;
    r0_req = 1; r0_addr = 12'h042; r0_we = 0;
    r1_req = 1; r1_addr = 12'h010; r1_we = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("t2_ack0", r0_ack, (c == 2 || c == 8) ? 1 : 0);
      chk("t2_ack1", r1_ack, (c == 5 || c == 11) ? 1 : 0);
      if (c % 3 == 0) chk("t2_addr", {ram_cs, ram_addr}, {1'b1, (c % 6 == 0) ? 12'h042 : 12'h010});
      if (c == 2) chk("t2_rd0", rd_pass, 16'h1234);
      if (c == 5) chk("t2_rd1", rd_pass, 16'h0A10);
    end
    r0_req = 0; r1_req = 0;
    idle1(); idle1();

    // reset during ACCESS aborts with no ack
    r0_req = 1; r0_addr = 12'h010; r0_we = 4'b0001; r0_pass_in = 16'hABCD;
    tick();
    chk("t5_cs", ram_cs, 1);
    chk("t5_rw", ram_pass_rw, GUARD ? 0 : 1);
    rst = 1; tick();
    chk("t5_cs_drop", ram_cs, 0);
    chk("t5_rw_drop", ram_pass_rw, 0);
    rst = 0; r0_req = 0; r0_we = 0;
    for (int i = 0; i < 4; i++) idle1();
    xfer(1, 12'h042, 4'b0000, 16'h0, 4'h0, 0, 1, 4'b0000, 0, 2);
    chk("t5_rd", rd_pass, 16'h1234);
    idle1();

`ifdef USER_RAM_LOCK_GUARD_EN
    // locked user refuses a pass write, accepts the unlock
    xfer(0, 12'h005, 4'b0001, 16'hBEEF, 4'h0, 0, 1, 4'b0000, 1, 4);
    chk("t6_rd_lock", {rd_pass, rd_lock}, {16'h0555, 1'b1});
    idle1();
    chk("t6_mem_pass", mem_pass[12'h005], 16'h0555);
    xfer(0, 12'h005, 4'b1000, 16'h0, 4'h0, 0, 1, 4'b0000, 0, 4);
    chk("t6_old_lock", rd_lock, 1);
    idle1();
    chk("t6_mem_lock", mem_lock[12'h005], 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
